// File: rtl/blood_alarm_controller.sv
// Alarm stage after bloodAbnormalityDetector: persistence filter, latched alarm,
// acknowledge/recover sequencing and a saturating alarm-event counter.
module blood_alarm_controller #(
  parameter int PERSIST = 3,
  parameter int CLEAR   = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sampleValid,
  input  logic             bloodAbnormality,
  input  logic             alarmAck,
  output logic             alarm,
  output logic [1:0]       state,
  output logic [3:0]       streak,
  output logic [CNT_W-1:0] eventCount
);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    SUSPECT = 2'b01,
    ALARM   = 2'b10,
    RECOVER = 2'b11
  } stateT;

  localparam logic [3:0] PERSIST4 = 4'(PERSIST);
  localparam logic [3:0] CLEAR4   = 4'(CLEAR);

  stateT      stateQ;
  logic [3:0] normRun;
  logic       isAbn;
  logic       isNrm;
  logic [3:0] streakNext;
  logic [3:0] normRunInc;
  logic       goAlarm;

  assign isAbn      = sampleValid & bloodAbnormality;
  assign isNrm      = sampleValid & ~bloodAbnormality;
  assign normRunInc = (normRun == 4'hF) ? normRun : normRun + 4'd1;
  assign state      = stateQ;

  always_comb begin
    streakNext = streak;
    if (isAbn) begin
      streakNext = (streak == 4'hF) ? streak : streak + 4'd1;
    end else if (isNrm) begin
      streakNext = 4'd0;
    end
  end

  // Every path into ALARM; shared so the event counter sees one strobe.
  always_comb begin
    goAlarm = 1'b0;
    case (stateQ)
      NORMAL:  goAlarm = isAbn && (PERSIST4 == 4'd1);
      SUSPECT: goAlarm = isAbn && (streakNext >= PERSIST4);
      RECOVER: goAlarm = isAbn;
      default: goAlarm = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= NORMAL;
      alarm      <= 1'b0;
      streak     <= 4'd0;
      normRun    <= 4'd0;
      eventCount <= '0;
    end else begin
      streak <= streakNext;

      if (isAbn) begin
        normRun <= 4'd0;
      end else if (isNrm && stateQ == RECOVER) begin
        normRun <= normRunInc;
      end

      if (goAlarm && eventCount != {CNT_W{1'b1}}) begin
        eventCount <= eventCount + 1'b1;
      end

      case (stateQ)
        NORMAL: begin
          if (goAlarm) begin
            stateQ <= ALARM;
            alarm  <= 1'b1;
          end else if (isAbn) begin
            stateQ <= SUSPECT;
          end
        end
        SUSPECT: begin
          if (goAlarm) begin
            stateQ <= ALARM;
            alarm  <= 1'b1;
          end else if (isNrm) begin
            stateQ <= NORMAL;
          end
        end
        ALARM: begin
          // A sample arriving with the ack must not count toward CLEAR.
          if (alarmAck) begin
            stateQ  <= RECOVER;
            alarm   <= 1'b0;
            normRun <= 4'd0;
          end
        end
        RECOVER: begin
          if (goAlarm) begin
            stateQ <= ALARM;
            alarm  <= 1'b1;
          end else if (isNrm && normRunInc >= CLEAR4) begin
            stateQ <= NORMAL;
          end
        end
        default: begin
          stateQ <= NORMAL;
          alarm  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blood_alarm_controller.sv
// Bench for blood_alarm_controller: two configurations share one stimulus stream
// and are compared every cycle against an integer reference model.
module tb_blood_alarm_controller;

  localparam int S_NORMAL  = 0;
  localparam int S_SUSPECT = 1;
  localparam int S_ALARM   = 2;
  localparam int S_RECOVER = 3;

  logic       clk;
  logic       rst;
  logic       sampleValid;
  logic       bloodAbnormality;
  logic       alarmAck;
  logic       alarm0;
  logic [1:0] state0;
  logic [3:0] streak0;
  logic [7:0] evt0;
  logic       alarm1;
  logic [1:0] state1;
  logic [3:0] streak1;
  logic [1:0] evt1;

  int checks = 0;
  int errors = 0;

  int P[2]   = '{3, 1};
  int C[2]   = '{2, 1};
  int SAT[2] = '{255, 3};
  int mState[2];
  int mStreak[2];
  int mNorm[2];
  int mEv[2];

  blood_alarm_controller #(.PERSIST(3), .CLEAR(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sampleValid(sampleValid),
    .bloodAbnormality(bloodAbnormality), .alarmAck(alarmAck),
    .alarm(alarm0), .state(state0), .streak(streak0), .eventCount(evt0)
  );

  blood_alarm_controller #(.PERSIST(1), .CLEAR(1), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .sampleValid(sampleValid),
    .bloodAbnormality(bloodAbnormality), .alarmAck(alarmAck),
    .alarm(alarm1), .state(state1), .streak(streak1), .eventCount(evt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic raise(input int c);
    mState[c] = S_ALARM;
    mEv[c]++;
  endtask

  task automatic modelStep(input int c, input bit r, input bit v, input bit b, input bit k);
    bit abn;
    bit nrm;
    abn = v && b;
    nrm = v && !b;
    if (r) begin
      mState[c] = S_NORMAL;
      mStreak[c] = 0;
      mNorm[c] = 0;
      mEv[c] = 0;
      return;
    end
    if (abn) mStreak[c] = (mStreak[c] < 15) ? mStreak[c] + 1 : 15;
    else if (nrm) mStreak[c] = 0;
    if (abn) mNorm[c] = 0;
    case (mState[c])
      S_NORMAL:
        if (abn) begin
          if (P[c] == 1) raise(c);
          else mState[c] = S_SUSPECT;
        end
      S_SUSPECT:
        if (nrm) mState[c] = S_NORMAL;
        else if (abn && mStreak[c] >= P[c]) raise(c);
      S_ALARM:
        if (k) begin
          mState[c] = S_RECOVER;
          mNorm[c] = 0;
        end
      default:
        if (abn) raise(c);
        else if (nrm) begin
          mNorm[c] = (mNorm[c] < 15) ? mNorm[c] + 1 : 15;
          if (mNorm[c] >= C[c]) mState[c] = S_NORMAL;
        end
    endcase
  endtask

  function automatic int evExp(input int c);
    return (mEv[c] < SAT[c]) ? mEv[c] : SAT[c];
  endfunction

  task automatic checkAll();
    chk("alarm0", {31'd0, alarm0}, (mState[0] == S_ALARM) ? 1 : 0);
    chk("state0", {30'd0, state0}, mState[0]);
    chk("streak0", {28'd0, streak0}, mStreak[0]);
    chk("evt0", {24'd0, evt0}, evExp(0));
    chk("alarm1", {31'd0, alarm1}, (mState[1] == S_ALARM) ? 1 : 0);
    chk("state1", {30'd0, state1}, mState[1]);
    chk("streak1", {28'd0, streak1}, mStreak[1]);
    chk("evt1", {30'd0, evt1}, evExp(1));
  endtask

  task automatic cyc(input bit r, input bit v, input bit b, input bit k);
    rst = r;
    sampleValid = v;
    bloodAbnormality = b;
    alarmAck = k;
    @(posedge clk);
    for (int c = 0; c < 2; c++) modelStep(c, r, v, b, k);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    rst = 1'b1;
    sampleValid = 1'b0;
    bloodAbnormality = 1'b0;
    alarmAck = 1'b0;

    repeat (2) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("rstAlarm", {31'd0, alarm0}, 0);
    chk("rstState", {30'd0, state0}, 0);
    chk("rstStreak", {28'd0, streak0}, 0);
    chk("rstEvt", {24'd0, evt0}, 0);

    // Persistence pattern 1,1,0,1,1,1
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    chk("persist3State", {30'd0, state0}, 0);
    chk("persist3Streak", {28'd0, streak0}, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    chk("persist5State", {30'd0, state0}, 1);
    chk("persist5Streak", {28'd0, streak0}, 2);
    cyc(0, 1, 1, 0);
    chk("persist6Alarm", {31'd0, alarm0}, 1);
    chk("persist6State", {30'd0, state0}, 2);
    chk("persist6Evt", {24'd0, evt0}, 1);

    // Ack with a normal sample, then normal, abnormal re-alarms
    cyc(0, 1, 0, 1);
    chk("ackState", {30'd0, state0}, 3);
    chk("ackAlarm", {31'd0, alarm0}, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("realarmState", {30'd0, state0}, 2);
    chk("realarmEvt", {24'd0, evt0}, 2);

    // Reset while in ALARM
    cyc(1, 1, 1, 1);
    chk("midRstAlarm", {31'd0, alarm0}, 0);
    chk("midRstState", {30'd0, state0}, 0);
    chk("midRstStreak", {28'd0, streak0}, 0);
    chk("midRstEvt", {24'd0, evt0}, 0);

    // Idle gaps do not break the run
    cyc(0, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    chk("gapAlarm", {31'd0, alarm0}, 1);
    chk("gapStreak", {28'd0, streak0}, 3);
    chk("gapEvt", {24'd0, evt0}, 1);

    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    chk("recover1State", {30'd0, state0}, 3);
    cyc(0, 1, 0, 0);
    chk("recover2State", {30'd0, state0}, 0);

    // Event counter and streak saturation
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    repeat (4) begin
      cyc(0, 0, 0, 1);
      cyc(0, 1, 1, 0);
    end
    chk("evtSat", {30'd0, evt1}, 3);
    repeat (20) cyc(0, 1, 1, 0);
    chk("streakSat0", {28'd0, streak0}, 15);
    chk("streakSat1", {28'd0, streak1}, 15);

    repeat (2000) begin
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) < 6, $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blood_alarm_controller.md
# blood_alarm_controller

Sequential alarm stage directly downstream of `bloodAbnormalityDetector`. It samples the detector's combinational `bloodAbnormality` flag on a per-sample strobe. It raises a latched `alarm` only after `PERSIST` consecutive abnormal samples, holds the alarm until the operator acknowledges it, and requires `CLEAR` consecutive normal samples before it re-arms. It also keeps a saturating count of alarm events for the monitoring front panel.

## Interface
- `PERSIST`, default 3: consecutive abnormal samples needed to raise an alarm; legal range 1..15.
- `CLEAR`, default 2: consecutive normal samples needed after acknowledge before returning to NORMAL; legal range 1..15.
- `CNT_W`, default 8: width of `eventCount`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sampleValid` in 1: a new detector result is present this cycle.
- `bloodAbnormality` in 1: detector output; only meaningful when `sampleValid`=1.
- `alarmAck` in 1: operator acknowledge; single-cycle pulse or level.
- `alarm` out 1: registered alarm output.
- `state` out 2: FSM state. NORMAL=00, SUSPECT=01, ALARM=10, RECOVER=11.
- `streak` out 4: consecutive abnormal valid samples, saturating at 15.
- `eventCount` out `CNT_W`: number of ALARM entries, saturating at all-ones.

## Operation
- A "sample" is a cycle with `sampleValid`=1. Cycles with `sampleValid`=0 change nothing except `alarmAck` handling. Idle gaps do not break a consecutive run.
- `streak` behaviour, independent of state:
  - An abnormal sample increments it, saturating at 15.
  - A normal sample clears it to 0.
- Internal `normRun` counter (4 bit, saturating) counts consecutive normal samples while in RECOVER. It clears on entry to RECOVER and on any abnormal sample.
- NORMAL:
  - An abnormal sample goes to SUSPECT, or to ALARM if `PERSIST`=1.
  - Otherwise the block stays in NORMAL.
- SUSPECT:
  - A normal sample returns to NORMAL.
  - An abnormal sample that makes `streak` (next value) reach `PERSIST` goes to ALARM.
  - Otherwise the block stays in SUSPECT.
- ALARM:
  - `alarmAck`=1 goes to RECOVER.
  - Samples are ignored for state purposes but still update `streak`.
- RECOVER:
  - An abnormal sample goes back to ALARM (re-alarm, counted as a new event).
  - A normal sample that makes `normRun` reach `CLEAR` goes to NORMAL.
  - `alarmAck` is ignored.
- `alarmAck` in NORMAL, SUSPECT or RECOVER has no effect.
- On every transition into ALARM, `eventCount` increments. Once it reaches 2^`CNT_W`−1 it holds.
- `alarm` = 1 exactly when the registered state is ALARM.
- Simultaneous events:
  - In ALARM, `alarmAck` and a sample in the same cycle: the block goes to RECOVER with `normRun`=0. That sample does not count toward `CLEAR`, but it does update `streak`.
  - In RECOVER, an abnormal sample always wins; there is no competing condition.
- Widths: `streak` and `normRun` compare against the parameters zero-extended to 4 bits. `eventCount` is an unsigned `CNT_W`-bit value.

## Timing
- Reset (`rst`=1 at an edge) sets `state`=NORMAL, `alarm`=0, `streak`=0, `normRun`=0 and `eventCount`=0 after that edge. Reset overrides all other inputs and applies mid-ALARM or mid-RECOVER too.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Alarm latency: the `PERSIST`-th consecutive abnormal sample is captured at edge k, and `alarm`=1 from edge k onward.
- Acknowledge latency: `alarmAck` captured at edge k gives `alarm`=0 and `state`=RECOVER after edge k.
- Re-alarm: an abnormal sample in RECOVER at edge k gives `alarm`=1 after edge k.
- There is no backpressure. One sample per cycle is sustainable indefinitely.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs → `alarm`=0, `state`=00, `streak`=0, `eventCount`=0.
- Persistence (`PERSIST`=3): samples abnormal pattern 1,1,0,1,1,1 on consecutive cycles.
  - After the third sample (0): `state`=00, `streak`=0.
  - After the fifth sample: `state`=01, `streak`=2.
  - After the sixth sample: `alarm`=1, `state`=10, `eventCount`=1.
- Gaps: abnormal samples 1 and 1 with 3 idle cycles between them, then a third 1 → `alarm`=1 after the third sample, `streak`=3.
- Acknowledge and recover (`CLEAR`=2), starting from ALARM:
  - `alarmAck` together with a normal sample → `state`=11, `alarm`=0.
  - Then normal, abnormal → `state`=10, `eventCount` incremented.
  - Then ack, normal, normal → `state`=00.
- Saturation: with `CNT_W`=2, produce 5 alarm events → `eventCount`=3. Then 20 consecutive abnormal samples → `streak`=15.
- Reset mid-operation: assert `rst` for one cycle while in ALARM with `eventCount`=2 → all outputs return to reset values on the next cycle, and a later alarm gives `eventCount`=1.
